// File: rtl/stopwatch_core.sv
// BCD stopwatch/timer engine: a chain of per-digit-modulus BCD digits counting up or
// down on a timebase tick, with run/pause, clear, digit adjust, lap freeze and countdown.
module stopwatch_core #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter logic [7:0]  MOD6_MASK  = 8'b0000_0010,
  parameter int unsigned SELW       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    down,
  input  logic                    adj,
  input  logic [SELW-1:0]         adj_sel,
  input  logic [3:0]              adj_val,
  input  logic                    adj_load,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic                    running,
  output logic                    lap_active,
  output logic                    zero,
  output logic                    wrap,
  output logic                    done
);

  localparam int unsigned CW = 4 * NUM_DIGITS;

  function automatic logic [3:0] digit_max(input logic [2:0] idx);
    return MOD6_MASK[idx] ? 4'd5 : 4'd9;
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] lap_q, lap_d;
  logic [CW-1:0] display_q, display_d;
  logic          running_q, running_d;
  logic          lap_active_q, lap_active_d;
  logic          zero_q, zero_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  logic [CW-1:0] up_cnt, dn_cnt;
  logic          all_max, dn_zero;
  logic          step_c;

  // Ripple carry/borrow across the digit chain, each digit with its own modulus
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    logic [3:0] mx;
    up_cnt = '0;
    dn_cnt = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    d      = '0;
    mx     = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      d  = count_q[4*i +: 4];
      mx = digit_max(3'(i));
      if (carry) begin
        if (d == mx) begin
          up_cnt[4*i +: 4] = 4'd0;
        end else begin
          up_cnt[4*i +: 4] = d + 4'd1;
          carry            = 1'b0;
        end
      end else begin
        up_cnt[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dn_cnt[4*i +: 4] = mx;
        end else begin
          dn_cnt[4*i +: 4] = d - 4'd1;
          borrow           = 1'b0;
        end
      end else begin
        dn_cnt[4*i +: 4] = d;
      end
    end
    all_max = carry;
    dn_zero = (dn_cnt == '0);
  end

  assign step_c = tick & running_q & ~adj;

  // Next-state: clear dominates; load and step are exclusive because step needs !adj
  always_comb begin
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    running_d    = running_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
    if (clear) begin
      count_d      = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
      running_d    = 1'b0;
    end else begin
      if (adj && adj_load) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (adj_sel == SELW'(i)) begin
            count_d[4*i +: 4] = (adj_val > digit_max(3'(i))) ? digit_max(3'(i)) : adj_val;
          end
        end
      end else if (step_c) begin
        count_d = down ? dn_cnt : up_cnt;
        wrap_d  = ~down & all_max;
        done_d  = down & dn_zero;
      end

      // A countdown may not be started from zero
      if (adj) begin
        running_d = 1'b0;
      end else if (start_stop && !(down && zero_q)) begin
        running_d = ~running_q;
      end else if (done_d) begin
        running_d = 1'b0;
      end

      if (lap) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (running_q) begin
          lap_d        = count_q;
          lap_active_d = 1'b1;
        end
      end
    end
    display_d = lap_active_d ? lap_d : count_d;
    zero_d    = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      lap_q        <= '0;
      display_q    <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      zero_q       <= 1'b1;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      lap_q        <= lap_d;
      display_q    <= display_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      zero_q       <= zero_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
    end
  end

  assign count      = count_q;
  assign display    = display_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign zero       = zero_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: the reference model keeps the count as a single
// integer in mixed radix and converts to BCD only when forming the expected outputs.
module tb_stopwatch_core;

  localparam int unsigned ND = 4;
  localparam logic [7:0]  M6 = 8'b0000_0010;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 4 * ND;

  logic          clk, rst, tick, start_stop, clear, lap, down, adj, adj_load;
  logic [SW-1:0] adj_sel;
  logic [3:0]    adj_val;
  logic [CW-1:0] count, display;
  logic          running, lap_active, zero, wrap, done;

  stopwatch_core #(.NUM_DIGITS(ND), .MOD6_MASK(M6), .SELW(SW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
    .lap(lap), .down(down), .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val),
    .adj_load(adj_load), .count(count), .display(display), .running(running),
    .lap_active(lap_active), .zero(zero), .wrap(wrap), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] count;
    logic [CW-1:0] display;
    logic          running;
    logic          lap_active;
    logic          zero;
    logic          wrap;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int mods[ND];
  int wts[ND];
  int total;
  int m_val, m_lapv;
  bit m_run, m_lapa;
  bit cur_down, cur_adj;

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(ND); i++) r[4*i +: 4] = 4'((v / wts[i]) % mods[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One stimulus cycle: drive inputs, advance the model, queue the expected outputs
  task automatic drive(input bit t, input bit ss, input bit clr, input bit lp,
                       input int sel, input int val, input bit ld);
    exp_t e;
    bit   wr, dn_ev, stp;
    int   nv, mx, nd, old;
    @(negedge clk);
    tick = t; start_stop = ss; clear = clr; lap = lp; down = cur_down; adj = cur_adj;
    adj_sel = SW'(sel); adj_val = 4'(val); adj_load = ld;
    wr = 1'b0; dn_ev = 1'b0;
    if (clr) begin
      m_val = 0; m_run = 1'b0; m_lapa = 1'b0; m_lapv = 0;
    end else begin
      stp = t && m_run && !cur_adj;
      nv  = m_val;
      if (cur_adj && ld) begin
        if (sel < int'(ND)) begin
          mx  = mods[sel] - 1;
          nd  = (val > mx) ? mx : val;
          old = (m_val / wts[sel]) % mods[sel];
          nv  = m_val + (nd - old) * wts[sel];
        end
      end else if (stp) begin
        if (cur_down) begin
          nv    = (m_val + total - 1) % total;
          dn_ev = (nv == 0);
        end else begin
          nv = (m_val + 1) % total;
          wr = (m_val == total - 1);
        end
      end
      if (lp) begin
        if (m_lapa) m_lapa = 1'b0;
        else if (m_run) begin m_lapv = m_val; m_lapa = 1'b1; end
      end
      if (cur_adj) m_run = 1'b0;
      else if (ss && !(cur_down && m_val == 0)) m_run = !m_run;
      else if (dn_ev) m_run = 1'b0;
      m_val = nv;
    end
    e.count      = to_bcd(m_val);
    e.display    = m_lapa ? to_bcd(m_lapv) : to_bcd(m_val);
    e.running    = m_run;
    e.lap_active = m_lapa;
    e.zero       = (m_val == 0);
    e.wrap       = wr;
    e.done       = dn_ev;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic ss_pulse();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic lap_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic load_value(input int d3, input int d2, input int d1, input int d0);
    cur_adj = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, d0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1, d1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2, d2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3, d3, 1'b1);
    cur_adj = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_display", 32'(display), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_lap_active", 32'(lap_active), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge
  task automatic async_reset();
    drain();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    m_val = 0; m_lapv = 0; m_run = 1'b0; m_lapa = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every cycle with a queued expectation is compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("count", 32'(count), 32'(e.count));
        chk("display", 32'(display), 32'(e.display));
        chk("running", 32'(running), 32'(e.running));
        chk("lap_active", 32'(lap_active), 32'(e.lap_active));
        chk("zero", 32'(zero), 32'(e.zero));
        chk("wrap", 32'(wrap), 32'(e.wrap));
        chk("done", 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    rst = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    down = 1'b0; adj = 1'b0; adj_sel = '0; adj_val = '0; adj_load = 1'b0;
    cur_down = 1'b0; cur_adj = 1'b0;
    total = 1;
    for (int i = 0; i < int'(ND); i++) begin
      mods[i] = (((M6 >> i) & 8'd1) != 8'd0) ? 6 : 10;
      wts[i]  = total;
      total   = total * mods[i];
    end
    m_val = 0; m_lapv = 0; m_run = 1'b0; m_lapa = 1'b0;

    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Up count, minute carry, full wrap
    ss_pulse();
    ticks(59);
    ticks(1);
    load_value(9, 9, 5, 9);
    ss_pulse();
    ticks(3);

    // Adjust clamping, out-of-range select, start blocked in adjust
    cur_adj = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1, 9, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5, 3, 1'b1);
    ss_pulse();
    cur_adj = 1'b0;
    idle(1);

    // Countdown to zero, done pulse, restart blocked at zero
    cur_down = 1'b1;
    load_value(0, 0, 0, 2);
    ss_pulse();
    ticks(2);
    ss_pulse();
    ticks(2);

    // Lap freeze and release
    cur_down = 1'b0;
    load_value(0, 0, 1, 2);
    ss_pulse();
    lap_pulse();
    ticks(3);
    lap_pulse();
    idle(1);

    // Tick and start_stop together
    load_value(0, 0, 0, 7);
    ss_pulse();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(1);

    // Async reset mid-count, then clear with tick
    load_value(0, 3, 4, 5);
    ss_pulse();
    ticks(2);
    async_reset();
    ss_pulse();
    ticks(4);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) cur_down = !cur_down;
      if ($urandom_range(0, 49) == 0) cur_adj = !cur_adj;
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 79) == 0), ($urandom_range(0, 14) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0));
    end
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
